// File: rtl/spike_event_logger_pkg.sv
// Shared definitions for the spike event logger.
// Entry layout helpers and neuron mask encodings.
package spike_event_logger_pkg;

  localparam int TS_LSB = 0;

  localparam logic [1:0] MASK_A = 2'b01;
  localparam logic [1:0] MASK_B = 2'b10;

  function automatic int entry_w(input int ts_w);
    return ts_w + 3;
  endfunction

  function automatic int mask_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int marker_bit(input int ts_w);
    return ts_w + 2;
  endfunction

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead FIFO with occupancy count and drop reporting.
// A push while full is only accepted if a pop frees a slot.
module sync_fifo_sa
  import spike_event_logger_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  rd_data_o,
  output logic          rd_valid_o,
  output logic          full_o,
  output logic [CW-1:0] count_o,
  output logic          drop_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign rd_valid_o = (count_q != '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign do_pop     = pop_i & rd_valid_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign drop_o     = push_i & full_o & ~do_pop;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)
        count_q <= count_q + 1'b1;
      else if (do_pop && !do_push)
        count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/spike_event_logger.sv
// Timestamps pre/post spike edges and queues them for a host.
// Timebase wrap rides in-band as the entry marker bit.
module spike_event_logger
  import spike_event_logger_pkg::*;
#(
  parameter int TS_WIDTH   = 5,
  parameter int DEPTH      = 8,
  parameter int PRESCALE_W = 4,
  localparam int ENTRY_W   = entry_w(TS_WIDTH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  spike_a,
  input  logic                  spike_b,
  input  logic                  rd_req,
  input  logic                  clr_overflow,
  output logic [ENTRY_W-1:0]    rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  overflow,
  output logic [CW-1:0]         count,
  output logic [TS_WIDTH-1:0]   ts_now
);

  logic                  spike_a_q;
  logic                  spike_b_q;
  logic                  arm_q;
  logic [PRESCALE_W-1:0] psc_q;
  logic [PRESCALE_W-1:0] psc_d;
  logic [TS_WIDTH-1:0]   ts_q;
  logic [TS_WIDTH-1:0]   ts_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  ev_a;
  logic                  ev_b;
  logic                  tick;
  logic                  wrap;
  logic [1:0]            mask;
  logic                  push;
  logic                  drop;
  logic [ENTRY_W-1:0]    entry;

  // arm_q keeps lines already high at reset release from counting as edges
  always_comb begin
    ev_a  = spike_a & ~spike_a_q & arm_q;
    ev_b  = spike_b & ~spike_b_q & arm_q;
    tick  = en & (psc_q == prescale);
    psc_d = psc_q;
    ts_d  = ts_q;
    if (en) psc_d = tick ? '0 : psc_q + 1'b1;
    if (tick) ts_d = ts_q + 1'b1;
    wrap  = tick & (&ts_q);
    mask  = (ev_a ? MASK_A : 2'b00) | (ev_b ? MASK_B : 2'b00);
    push  = en & ((|mask) | wrap);
    entry = '0;
    entry[marker_bit(TS_WIDTH)]       = wrap;
    entry[mask_lsb(TS_WIDTH) +: 2]    = mask;
    entry[TS_LSB +: TS_WIDTH]         = ts_q;
    ovf_d = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spike_a_q <= 1'b0;
      spike_b_q <= 1'b0;
      arm_q     <= 1'b0;
      psc_q     <= '0;
      ts_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      spike_a_q <= spike_a;
      spike_b_q <= spike_b;
      arm_q     <= 1'b1;
      psc_q     <= psc_d;
      ts_q      <= ts_d;
      ovf_q     <= ovf_d;
    end
  end

  sync_fifo_sa #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .data_i     (entry),
    .pop_i      (rd_req),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid),
    .full_o     (full),
    .count_o    (count),
    .drop_o     (drop)
  );

  assign overflow = ovf_q;
  assign ts_now   = ts_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger.
// Expected entries are hand-derived from the tick/timestamp schedule.
module tb_spike_event_logger;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] prescale;
  logic       spike_a;
  logic       spike_b;
  logic       rd_req;
  logic       clr_overflow;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       overflow;
  logic [3:0] count;
  logic [4:0] ts_now;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spike_event_logger dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .prescale     (prescale),
    .spike_a      (spike_a),
    .spike_b      (spike_b),
    .rd_req       (rd_req),
    .clr_overflow (clr_overflow),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .overflow     (overflow),
    .count        (count),
    .ts_now       (ts_now)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    en           = 1'b1;
    prescale     = 4'd0;
    spike_a      = 1'b0;
    spike_b      = 1'b0;
    rd_req       = 1'b0;
    clr_overflow = 1'b0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_ts", 32'(ts_now), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_full", 32'(full), 0);
    step(2);
    reset_n = 1'b1;

    // single a pulse at ts=3
    step(3);
    chk("t1_ts3", 32'(ts_now), 3);
    spike_a = 1'b1;
    step();
    chk("t1_valid", 32'(rd_valid), 1);
    chk("t1_data", 32'(rd_data), 32'h23);
    chk("t1_count", 32'(count), 1);
    spike_a = 1'b0;
    rd_req  = 1'b1;
    step();
    rd_req  = 1'b0;
    chk("t1_popped", 32'(rd_valid), 0);

    // simultaneous a/b at ts=7, held high
    step(2);
    chk("t2_ts7", 32'(ts_now), 7);
    spike_a = 1'b1;
    spike_b = 1'b1;
    step();
    chk("t2_data", 32'(rd_data), 32'h67);
    chk("t2_count", 32'(count), 1);
    step(5);
    chk("t2_held", 32'(count), 1);
    spike_a = 1'b0;
    spike_b = 1'b0;
    rd_req  = 1'b1;
    step();
    rd_req  = 1'b0;
    chk("t2_empty", 32'(count), 0);

    // pure wrap marker, then wrap with b event
    step(17);
    chk("t3_ts31", 32'(ts_now), 31);
    chk("t3_none", 32'(count), 0);
    step();
    chk("t3_wcount", 32'(count), 1);
    chk("t3_wdata", 32'(rd_data), 32'h9F);
    chk("t3_ts0", 32'(ts_now), 0);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step(30);
    chk("t3_ts31b", 32'(ts_now), 31);
    chk("t3_noextra", 32'(count), 0);
    spike_b = 1'b1;
    step();
    chk("t3_bwdata", 32'(rd_data), 32'hDF);
    chk("t3_bwcount", 32'(count), 1);
    spike_b = 1'b0;
    rd_req  = 1'b1;
    step();
    rd_req  = 1'b0;
    chk("t3_empty", 32'(count), 0);

    // prescale=3, then freeze mid-count with en=0
    prescale = 4'd3;
    step(3);
    chk("t4_hold3", 32'(ts_now), 1);
    step();
    chk("t4_tick", 32'(ts_now), 2);
    step(2);
    en      = 1'b0;
    spike_a = 1'b1;
    step();
    spike_a = 1'b0;
    step(9);
    chk("t4_frozen", 32'(ts_now), 2);
    chk("t4_nolog", 32'(count), 0);
    en = 1'b1;
    step();
    chk("t4_psc_kept", 32'(ts_now), 2);
    step();
    chk("t4_resume", 32'(ts_now), 3);

    // overflow: 9 pulses at ts 3,5,..,19
    prescale = 4'd0;
    for (int i = 0; i < 9; i++) begin
      spike_a = 1'b1;
      step();
      spike_a = 1'b0;
      step();
    end
    chk("t5_count", 32'(count), 8);
    chk("t5_full", 32'(full), 1);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_head", 32'(rd_data), 32'h23);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("t5_clr", 32'(overflow), 0);
    spike_a = 1'b1;
    rd_req  = 1'b1;
    step();
    spike_a = 1'b0;
    rd_req  = 1'b0;
    chk("t5_pp_count", 32'(count), 8);
    chk("t5_pp_full", 32'(full), 1);
    chk("t5_pp_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_rd%0d", i), 32'(rd_data),
          (i < 7) ? 32'h20 + 32'(5 + 2 * i) : 32'h36);
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
    end
    chk("t5_drained", 32'(count), 0);
    chk("t5_novalid", 32'(rd_valid), 0);
    chk("t5_ts31", 32'(ts_now), 31);

    // event in wrap cycle, then reset with count=5
    spike_a = 1'b1;
    step();
    spike_a = 1'b0;
    chk("t6_awrap", 32'(rd_data), 32'hBF);
    step();
    for (int i = 0; i < 4; i++) begin
      spike_a = 1'b1;
      step();
      spike_a = 1'b0;
      step();
    end
    chk("t6_count5", 32'(count), 5);
    spike_a = 1'b1;
    spike_b = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_valid", 32'(rd_valid), 0);
    chk("t6_data", 32'(rd_data), 0);
    chk("t6_ts", 32'(ts_now), 0);
    chk("t6_full", 32'(full), 0);
    chk("t6_ovf", 32'(overflow), 0);
    step(2);
    reset_n = 1'b1;
    step();
    chk("t6_noev1", 32'(count), 0);
    step(2);
    chk("t6_noev3", 32'(count), 0);
    spike_a = 1'b0;
    spike_b = 1'b0;
    step();
    spike_a = 1'b1;
    step();
    chk("t6_newcount", 32'(count), 1);
    chk("t6_newdata", 32'(rd_data), 32'h24);
    spike_a = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spike_event_logger.md
Name: spike_event_logger

Overview:
- Downstream consumer of the LIF/STDP neuron pair. Timestamps spike events from two neurons (pre and post) and buffers them in a small show-ahead FIFO.
- A host or test harness drains the FIFO one byte-wide entry per read handshake.
- Timestamp wrap is encoded in-band so the host can reconstruct absolute time.
- Neuron internals are not modified; the block only observes the two spike lines.

Parameters:
- TS_WIDTH, 5, timestamp field width in ticks.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- PRESCALE_W, 4, width of the tick prescaler setting.
- ENTRY_W, 3+TS_WIDTH, derived: entry = {marker, mask[1:0], ts[TS_WIDTH-1:0]}. Not overridable.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  logging/timebase enable.
- prescale  in  PRESCALE_W  tick period minus 1, in clk cycles.
- spike_a  in  1  neuron 1 spike, pre-synaptic.
- spike_b  in  1  neuron 2 spike, post-synaptic.
- rd_req  in  1  pop request.
- clr_overflow  in  1  clears the sticky overflow flag.
- rd_data  out  ENTRY_W  head entry; valid when rd_valid=1.
- rd_valid  out  1  FIFO not empty.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky flag: an entry was dropped.
- count  out  $clog2(DEPTH)+1  occupancy.
- ts_now  out  TS_WIDTH  current timestamp.

Behaviour:
- Reset: all outputs and internal state clear.
  - count=0, rd_valid=0, full=0, overflow=0, rd_data=0, ts_now=0.
  - Prescaler=0, edge registers=0, FIFO pointers=0.
- Edge detect:
  - ev_a = spike_a & ~spike_a_q; ev_b likewise.
  - The _q registers update every cycle, regardless of en.
  - A level held high yields exactly one event.
- Prescaler:
  - When en=1: psc counts 0..prescale.
  - tick = en & (psc==prescale); psc returns to 0 on tick.
  - prescale=0 gives a tick every cycle.
  - When en=0: psc and ts_now hold.
  - A prescale change mid-count takes effect on the next compare; if psc>prescale, psc counts up through 2^PRESCALE_W wrap. No special handling.
- Timestamp:
  - ts_now increments on tick, modulo 2^TS_WIDTH.
  - wrap = tick & (ts_now == all ones).
- Entry formation, evaluated each cycle with en=1:
  - mask = {ev_b, ev_a}.
  - push = (mask!=0) | wrap.
  - Entry = {wrap, mask, ts_now}, where ts_now is the value before this edge's increment.
  - marker=1 means "timebase wrapped after this entry's timestamp".
  - mask=00 with marker=1 is a pure wrap marker.
  - Simultaneous a/b events share one entry (mask=11).
  - At most one push per cycle; there is no loss from event/wrap collision.
  - en=0: no push.
- Latency: an event is sampled at edge N, and the entry is written at edge N.
  - If the FIFO was empty, rd_valid=1 and rd_data shows the entry after edge N.
- FIFO (show-ahead):
  - rd_data = mem[rd_ptr].
  - pop = rd_req & rd_valid; rd_req while empty is ignored.
  - Push and pop in the same cycle: both occur, count unchanged. This is legal even when full, with no overflow.
  - Push while full without pop: entry dropped, overflow<=1, pointers unchanged.
  - Push and pop while empty: the push occurs, and the pop is ignored because rd_valid=0.
  - Pointers use modulo-DEPTH wrap.
- Overflow flag: clr_overflow clears it.
  - A same-cycle drop wins, so the flag ends at 1.
- Reset mid-operation: immediate asynchronous clear. In-flight entries are lost; no event is generated from spike lines high at release until they go low then high.

Decomposition:
- Shared package holds:
  - ENTRY_W derivation.
  - Field offsets MARKER_BIT, MASK_LSB, TS_LSB.
  - Mask encodings for neuron A/B.
- One natural sub-module: sync_fifo_sa, the generic show-ahead FIFO with count, full and push-drop reporting.
  - The logger top holds the edge detect, prescaler, timestamp and entry packing.

Test Plan:
- Reset then en=1, prescale=0, one spike_a pulse at ts_now=3 -> next cycle rd_valid=1, rd_data=8'b0_01_00011, count=1. Pop -> rd_valid=0.
- spike_a and spike_b rise in the same cycle at ts=7 -> single entry 8'b0_11_00111. Level held for 5 cycles -> no further entries.
- prescale=0, no spikes for 32 cycles -> exactly one entry 8'b1_00_11111, and ts_now returns to 0. With spike_b in the wrap cycle -> single entry 8'b1_10_11111.
- prescale=3 -> ts_now increments every 4 cycles. en=0 for 10 cycles -> ts_now and psc frozen, and spikes are not logged.
- 9 events with no reads, DEPTH=8 -> full=1, count=8, overflow=1. The first 8 entries read back in order. clr_overflow -> 0. Push+pop while full -> count stays 8, overflow stays 0.
- Assert reset_n low while count=5 -> all outputs 0 immediately. Spike lines high at release -> no entry until a new rising edge.
